cellnet_sink_monitor: RTL

CELLNET_SINK_MONITOR -- requirements
Module: cellnet_sink_monitor

---
 rtl/cellnet_sink_monitor_pkg.sv | 25 ++
 rtl/cellnet_sink_ch.sv | 68 ++++++
 rtl/cellnet_sink_monitor.sv | 110 +++++++++++
 3 files changed

// File: rtl/cellnet_sink_monitor_pkg.sv
// Shared cellnet defines (the former global.v contents) and sink-monitor types.
// The defines are guarded so an existing global.v may supply them instead.
`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 8
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 8
`endif
`ifndef SINK_ST_IDLE
`define SINK_ST_IDLE 1'b0
`endif
`ifndef SINK_ST_ACKD
`define SINK_ST_ACKD 1'b1
`endif

package cellnet_sink_monitor_pkg;

  typedef enum logic {
    ST_IDLE = `SINK_ST_IDLE,
    ST_ACKD = `SINK_ST_ACKD
  } sink_state_e;

  localparam int unsigned SEL_W = 4;

endpackage

// File: rtl/cellnet_sink_ch.sv
// One req/ack sink channel: 4-phase handshake FSM, capture registers and a
// saturating message counter.
module cellnet_sink_ch
  import cellnet_sink_monitor_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              hold,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dat,
  output logic              ack,
  output logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] last_dat,
  output logic [CNT_W-1:0]  cnt,
  output logic              sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  sink_state_e      state_q, state_d;
  logic             capture;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hold) begin
          state_d = ST_ACKD;
          capture = 1'b1;
        end
      end
      ST_ACKD: begin
        if (!req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      last_addr <= '0;
      last_dat  <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        last_addr <= addr;
        last_dat  <= dat;
        cnt       <= cnt_inc;
        if (cnt_inc == CNT_MAX) sat <= 1'b1;
      end
    end
  end

  assign ack = (state_q == ST_ACKD);

endmodule

// File: rtl/cellnet_sink_monitor.sv
// Multi-channel req/ack sink with a debug snapshot port: button-style edge
// detectors pick a channel (i_next) and latch its captured state (i_snap).
module cellnet_sink_monitor
  import cellnet_sink_monitor_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = `ADDRESS_SIZE,
  parameter int unsigned DATA_W = `DATA_SIZE,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_dat,
  output logic [NUM_CH-1:0]        o_ack,
  input  logic                     i_hold,
  input  logic                     i_snap,
  input  logic                     i_next,
  output logic [SEL_W-1:0]         o_sel,
  output logic [ADDR_W-1:0]        o_disp_addr,
  output logic [DATA_W-1:0]        o_disp_dat,
  output logic [CNT_W-1:0]         o_disp_cnt,
  output logic [NUM_CH-1:0]        o_sat
);

  logic [ADDR_W-1:0] ch_addr [NUM_CH];
  logic [DATA_W-1:0] ch_dat  [NUM_CH];
  logic [CNT_W-1:0]  ch_cnt  [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cellnet_sink_ch #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .req      (i_req[k]),
      .hold     (i_hold),
      .addr     (i_addr[k*ADDR_W +: ADDR_W]),
      .dat      (i_dat[k*DATA_W +: DATA_W]),
      .ack      (o_ack[k]),
      .last_addr(ch_addr[k]),
      .last_dat (ch_dat[k]),
      .cnt      (ch_cnt[k]),
      .sat      (o_sat[k])
    );
  end

  logic snap_cur, snap_prev, next_cur, next_prev, armed;
  logic snap_edge, next_edge;

  // On the first edge after reset, prev is loaded with the live input so a
  // level already high at release is not mistaken for a rising edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      snap_cur  <= 1'b0;
      snap_prev <= 1'b0;
      next_cur  <= 1'b0;
      next_prev <= 1'b0;
      armed     <= 1'b0;
    end else begin
      snap_cur  <= i_snap;
      next_cur  <= i_next;
      snap_prev <= armed ? snap_cur : i_snap;
      next_prev <= armed ? next_cur : i_next;
      armed     <= 1'b1;
    end
  end

  assign snap_edge = snap_cur & ~snap_prev;
  assign next_edge = next_cur & ~next_prev;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_dat;
  logic [CNT_W-1:0]  sel_cnt;

  always_comb begin
    sel_addr = '0;
    sel_dat  = '0;
    sel_cnt  = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (o_sel == SEL_W'(k)) begin
        sel_addr = ch_addr[k];
        sel_dat  = ch_dat[k];
        sel_cnt  = ch_cnt[k];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sel       <= '0;
      o_disp_addr <= '0;
      o_disp_dat  <= '0;
      o_disp_cnt  <= '0;
    end else begin
      if (next_edge) begin
        o_sel <= (o_sel == SEL_W'(NUM_CH - 1)) ? '0 : o_sel + SEL_W'(1);
      end
      if (snap_edge) begin
        o_disp_addr <= sel_addr;
        o_disp_dat  <= sel_dat;
        o_disp_cnt  <= sel_cnt;
      end
    end
  end

endmodule
